arcino_multdiv_ctrl: RTL and testbench
======================================

Name: arcino_multdiv_ctrl

Overview:
Issue/writeback controller directly upstream of the slow multiply/divide engine. It accepts one decoded RV32M request from the ID stage, latches the operands and destination, and maps funct3 onto the engine's operator and signed mode. It holds the engine enables until the engine reports ready, captures the result, and presents it to writeback on a valid/ready handshake. It also handles pipeline flush. Only one operation is in flight at a time.

Parameters:
RD_W, 5, destination register index width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  ID stage presents an M-extension instruction
req_ready_o  out  1  controller can accept a request
req_funct3_i  in  3  RV32M funct3
req_op_a_i  in  32  rs1 value
req_op_b_i  in  32  rs2 value
req_rd_i  in  RD_W  destination register
kill_i  in  1  flush; discard the in-flight or pending operation
mult_en_o  out  1  engine multiply enable
div_en_o  out  1  engine divide enable
operator_o  out  2  md_op_e value: MD_OP_MULL=0, MD_OP_MULH=1, MD_OP_DIV=2, MD_OP_REM=3
signed_mode_o  out  2  bit0 = op A signed, bit1 = op B signed
op_a_o  out  32  latched operand A
op_b_o  out  32  latched operand B
multdiv_result_i  in  32  engine result
multdiv_ready_i  in  1  engine result valid this cycle
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback accepts
wb_data_o  out  32  result
wb_rd_o  out  RD_W  destination
busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high, on rst_i. rst_i must also reset the engine; the top level drives the engine's rst_ni from ~rst_i.
- Reset values: state=IDLE; all outputs 0 except req_ready_o=1. Latched operands, funct3, rd and result are all 0.
- funct3 decode, giving operator/signed_mode:
  - 000 MUL → MULL/00
  - 001 MULH → MULH/11
  - 010 MULHSU → MULH/01
  - 011 MULHU → MULH/00
  - 100 DIV → DIV/11
  - 101 DIVU → DIV/00
  - 110 REM → REM/11
  - 111 REMU → REM/00
- operator_o, signed_mode_o, op_a_o and op_b_o come from registered values and are stable from acceptance until return to IDLE.
- mult_en_o = (RUN|DRAIN) & operator in {MULL,MULH}; div_en_o = (RUN|DRAIN) & operator in {DIV,REM}. Both are decoded directly from registers.
- FSM states: IDLE, RUN, RESP, DRAIN.
  - IDLE: req_ready_o=1. On req_valid_i & !kill_i: latch funct3, A, B and rd; go to RUN. If kill_i is high, the request is ignored.
  - RUN: enables high. On multdiv_ready_i, capture multdiv_result_i that same cycle (the multiply result is combinational and valid only in the ready cycle). Then go to IDLE if kill_i, else RESP. On kill_i without ready, go to DRAIN.
  - DRAIN: enables stay high, because the engine has no abort and freezes if its enable drops. On multdiv_ready_i, discard the result and go to IDLE.
  - RESP: wb_valid_o=1 and enables low. wb_data_o/wb_rd_o hold stable while wb_valid_o is high. wb_ready_i → IDLE. kill_i → IDLE with no write; kill_i has priority over wb_ready_i.
- Enables are high in every cycle up to and including the multdiv_ready_i cycle, and low in the following cycle. This lets the engine return to its idle state.
- req_ready_o is high only in IDLE (no combinational path from wb_ready_i). Minimum issue interval is request → RUN → RESP → IDLE.
- multdiv_ready_i outside RUN/DRAIN is ignored.
- Divide-by-zero and signed overflow results are produced by the engine and forwarded unmodified.
- Reset mid-operation: the next state is IDLE regardless of current state. Nothing is written back.

Test Plan:
1. MUL (000), A=7, B=6, rd=5 → operator_o=0, signed_mode_o=00, mult_en_o high until ready; wb_valid_o with wb_data_o=42, wb_rd_o=5; req_ready_o=1 the cycle after wb_ready_i.
2. A=B=0xFFFFFFFF with MULH / MULHSU / MULHU → wb_data_o=0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE; signed_mode_o 11 / 01 / 00.
3. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000; REM same operands → 0; DIVU 20/0 → 0xFFFFFFFF; REMU 20/0 → 20; div_en_o high and mult_en_o low throughout.
4. DIV 100/7 with kill_i pulsed 3 cycles after acceptance → div_en_o stays high until multdiv_ready_i, then drops; wb_valid_o is never asserted; req_ready_o=0 until DRAIN exits. Next request MUL 3*3 → 9.
5. MUL 5*5 with wb_ready_i low for 5 cycles → wb_valid_o=1 and wb_data_o=25 held constant; req_ready_o=0 and enables low throughout; new req_valid_i is not accepted until after the handshake.
6. rst_i asserted mid-DIV (engine also reset) → next cycle state IDLE, all enables 0, wb_valid_o=0, req_ready_o=1. A subsequent DIVU 9/2 → 4.

Source files
------------

// File: rtl/arcino_multdiv_ctrl.sv
// Issue/writeback controller in front of the iterative RV32M multiply/divide engine.
// Latches one request, keeps the engine enabled until it reports ready, then hands the result to writeback.
module arcino_multdiv_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_funct3_i,
    input  logic [31:0]     req_op_a_i,
    input  logic [31:0]     req_op_b_i,
    input  logic [RD_W-1:0] req_rd_i,
    input  logic            kill_i,
    output logic            mult_en_o,
    output logic            div_en_o,
    output logic [1:0]      operator_o,
    output logic [1:0]      signed_mode_o,
    output logic [31:0]     op_a_o,
    output logic [31:0]     op_b_o,
    input  logic [31:0]     multdiv_result_i,
    input  logic            multdiv_ready_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [31:0]     wb_data_o,
    output logic [RD_W-1:0] wb_rd_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    state_e          state_reg, state_next;
    logic [2:0]      funct3_reg;
    logic [31:0]     op_a_reg;
    logic [31:0]     op_b_reg;
    logic [RD_W-1:0] rd_reg;
    logic [31:0]     result_reg;
    logic            accept;
    logic            capture;
    logic            engine_on;
    md_op_e          operator_dec;
    logic [1:0]      signed_mode_dec;

    // Operator and signedness come from the latched funct3, so they cannot move mid-operation.
    always_comb begin
        operator_dec    = MD_OP_MULL;
        signed_mode_dec = 2'b00;
        unique case (funct3_reg)
            3'b000: begin operator_dec = MD_OP_MULL; signed_mode_dec = 2'b00; end
            3'b001: begin operator_dec = MD_OP_MULH; signed_mode_dec = 2'b11; end
            3'b010: begin operator_dec = MD_OP_MULH; signed_mode_dec = 2'b01; end
            3'b011: begin operator_dec = MD_OP_MULH; signed_mode_dec = 2'b00; end
            3'b100: begin operator_dec = MD_OP_DIV;  signed_mode_dec = 2'b11; end
            3'b101: begin operator_dec = MD_OP_DIV;  signed_mode_dec = 2'b00; end
            3'b110: begin operator_dec = MD_OP_REM;  signed_mode_dec = 2'b11; end
            3'b111: begin operator_dec = MD_OP_REM;  signed_mode_dec = 2'b00; end
            default: begin operator_dec = MD_OP_MULL; signed_mode_dec = 2'b00; end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (req_valid_i && !kill_i) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // The multiply result is only valid during the ready cycle, so grab it there.
                if (multdiv_ready_i) begin
                    capture    = 1'b1;
                    state_next = kill_i ? IDLE : RESP;
                end else if (kill_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (multdiv_ready_i) begin
                    state_next = IDLE;
                end
            end
            RESP: begin
                if (kill_i || wb_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            funct3_reg <= 3'b000;
            op_a_reg   <= 32'd0;
            op_b_reg   <= 32'd0;
            rd_reg     <= '0;
            result_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                funct3_reg <= req_funct3_i;
                op_a_reg   <= req_op_a_i;
                op_b_reg   <= req_op_b_i;
                rd_reg     <= req_rd_i;
            end
            if (capture) begin
                result_reg <= multdiv_result_i;
            end
        end
    end

    // The engine has no abort, so DRAIN keeps it enabled until it finishes on its own.
    assign engine_on     = (state_reg == RUN) || (state_reg == DRAIN);
    assign mult_en_o     = engine_on && ((operator_dec == MD_OP_MULL) || (operator_dec == MD_OP_MULH));
    assign div_en_o      = engine_on && ((operator_dec == MD_OP_DIV) || (operator_dec == MD_OP_REM));
    assign operator_o    = operator_dec;
    assign signed_mode_o = signed_mode_dec;
    assign op_a_o        = op_a_reg;
    assign op_b_o        = op_b_reg;
    assign req_ready_o   = (state_reg == IDLE);
    assign wb_valid_o    = (state_reg == RESP);
    assign wb_data_o     = result_reg;
    assign wb_rd_o       = rd_reg;
    assign busy_o        = (state_reg != IDLE);

endmodule

// File: tb/tb_arcino_multdiv_ctrl.sv
// Directed bench for arcino_multdiv_ctrl with a behavioural multi-cycle engine and a writeback scoreboard.
module tb_arcino_multdiv_ctrl;

    localparam int RD_W = 5;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_funct3_i;
    logic [31:0]     req_op_a_i;
    logic [31:0]     req_op_b_i;
    logic [RD_W-1:0] req_rd_i;
    logic            kill_i;
    logic            mult_en_o;
    logic            div_en_o;
    logic [1:0]      operator_o;
    logic [1:0]      signed_mode_o;
    logic [31:0]     op_a_o;
    logic [31:0]     op_b_o;
    logic [31:0]     multdiv_result_i;
    logic            multdiv_ready_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [31:0]     wb_data_o;
    logic [RD_W-1:0] wb_rd_o;
    logic            busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
    } exp_t;
    exp_t sb[$];

    always #5 clk_i = ~clk_i;

    arcino_multdiv_ctrl #(.RD_W(RD_W)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_funct3_i     (req_funct3_i),
        .req_op_a_i       (req_op_a_i),
        .req_op_b_i       (req_op_b_i),
        .req_rd_i         (req_rd_i),
        .kill_i           (kill_i),
        .mult_en_o        (mult_en_o),
        .div_en_o         (div_en_o),
        .operator_o       (operator_o),
        .signed_mode_o    (signed_mode_o),
        .op_a_o           (op_a_o),
        .op_b_o           (op_b_o),
        .multdiv_result_i (multdiv_result_i),
        .multdiv_ready_i  (multdiv_ready_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_data_o        (wb_data_o),
        .wb_rd_o          (wb_rd_o),
        .busy_o           (busy_o)
    );

    // Engine stand-in: computes from the controller's operator/signed_mode/operands, not from funct3.
    function automatic logic [31:0] eng_calc(input logic [1:0] op, input logic [1:0] sm,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] sa;
        logic signed [32:0] sb_v;
        logic signed [65:0] p;
        logic signed [31:0] q;
        logic               ovf;
        sa   = {sm[0] & a[31], a};
        sb_v = {sm[1] & b[31], b};
        p    = 66'(sa) * 66'(sb_v);
        ovf  = (sm == 2'b11) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                if (sm == 2'b11) begin q = $signed(a) / $signed(b); return q; end
                return a / b;
            end
            default: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                if (sm == 2'b11) begin q = $signed(a) % $signed(b); return q; end
                return a % b;
            end
        endcase
    endfunction

    logic [3:0] eng_lat;
    logic [3:0] eng_cnt;
    logic       eng_rdy;

    always @(posedge clk_i) begin
        if (rst_i) begin
            eng_cnt <= 4'd0;
            eng_rdy <= 1'b0;
        end else if ((mult_en_o || div_en_o) && !eng_rdy) begin
            if (eng_cnt == 4'(eng_lat - 4'd1)) begin
                eng_rdy <= 1'b1;
                eng_cnt <= 4'd0;
            end else begin
                eng_cnt <= eng_cnt + 4'd1;
            end
        end else begin
            eng_rdy <= 1'b0;
        end
    end

    assign multdiv_ready_i  = eng_rdy;
    assign multdiv_result_i = eng_rdy ? eng_calc(operator_o, signed_mode_o, op_a_o, op_b_o)
                                      : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd);
        @(negedge clk_i);
        chk("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
        req_valid_i  = 1'b1;
        req_funct3_i = f3;
        req_op_a_i   = a;
        req_op_b_i   = b;
        req_rd_i     = rd;
        @(negedge clk_i);
        req_valid_i  = 1'b0;
        req_op_a_i   = 32'h0BAD_0BAD;
        req_op_b_i   = 32'h0BAD_0BAD;
        $display("issue f3=%0d a=0x%08h b=0x%08h rd=%0d", f3, a, b, rd);
    endtask

    // Called in the first RUN cycle; returns after the cycle following multdiv_ready_i.
    task automatic wait_ready(input logic [1:0] exp_op);
        int guard = 0;
        chk("mult_en_run", {31'd0, mult_en_o}, {31'd0, exp_op < 2'd2});
        chk("div_en_run",  {31'd0, div_en_o},  {31'd0, exp_op >= 2'd2});
        while (!multdiv_ready_i && guard < 64) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 64) chk("ready_timeout", 32'd0, 32'd1);
        chk("en_in_ready_cycle", {31'd0, mult_en_o | div_en_o}, 32'd1);
        @(negedge clk_i);
        chk("en_after_ready", {30'd0, mult_en_o, div_en_o}, 32'd0);
    endtask

    task automatic finish_wb(input int hold);
        exp_t e;
        logic [31:0] held;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk("wb_valid", {31'd0, wb_valid_o}, 32'd1);
        held = wb_data_o;
        for (int i = 0; i < hold; i++) begin
            req_valid_i  = 1'b1;
            req_funct3_i = 3'b000;
            chk("hold_req_ready", {31'd0, req_ready_o}, 32'd0);
            chk("hold_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
            chk("hold_data", wb_data_o, held);
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        chk("wb_data", wb_data_o, e.data);
        chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
        $display("writeback rd=%0d data=0x%08h expected=0x%08h", wb_rd_o, wb_data_o, e.data);
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        wb_ready_i = 1'b0;
        chk("req_ready_after_wb", {31'd0, req_ready_o}, 32'd1);
        chk("wb_valid_after_wb", {31'd0, wb_valid_o}, 32'd0);
    endtask

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [RD_W-1:0] rd, input logic [31:0] exp_v,
                          input logic [1:0] exp_op, input logic [1:0] exp_sm, input int hold);
        sb.push_back('{data: exp_v, rd: rd});
        issue(f3, a, b, rd);
        chk("operator", {30'd0, operator_o}, {30'd0, exp_op});
        chk("signed_mode", {30'd0, signed_mode_o}, {30'd0, exp_sm});
        chk("op_a", op_a_o, a);
        chk("op_b", op_b_o, b);
        wait_ready(exp_op);
        finish_wb(hold);
    endtask

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_funct3_i = 3'b000;
        req_op_a_i   = 32'd0;
        req_op_b_i   = 32'd0;
        req_rd_i     = '0;
        kill_i       = 1'b0;
        wb_ready_i   = 1'b0;
        eng_lat      = 4'd3;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_outputs", {27'd0, mult_en_o, div_en_o, wb_valid_o, busy_o, operator_o != 2'd0}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);

        // Request under kill in IDLE is dropped.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        kill_i      = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        kill_i      = 1'b0;
        chk("kill_idle_busy", {31'd0, busy_o}, 32'd0);

        run_op(3'b000, 32'd7, 32'd6, 5'd5, 32'd42, 2'd0, 2'b00, 0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 2'd1, 2'b11, 0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 2'd1, 2'b01, 0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 2'd1, 2'b00, 0);

        eng_lat = 4'd8;
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 2'd2, 2'b11, 0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 2'd3, 2'b11, 0);
        run_op(3'b101, 32'd20, 32'd0, 5'd12, 32'hFFFF_FFFF, 2'd2, 2'b00, 0);
        run_op(3'b111, 32'd20, 32'd0, 5'd13, 32'd20, 2'd3, 2'b00, 0);

        // Kill during RUN: engine drains, nothing is written back.
        eng_lat = 4'd10;
        issue(3'b100, 32'd100, 32'd7, 5'd7);
        @(negedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(negedge clk_i);
        kill_i = 1'b0;
        begin
            int guard = 0;
            while (!multdiv_ready_i && guard < 64) begin
                chk("drain_div_en", {31'd0, div_en_o}, 32'd1);
                chk("drain_req_ready", {31'd0, req_ready_o}, 32'd0);
                chk("drain_wb_valid", {31'd0, wb_valid_o}, 32'd0);
                @(negedge clk_i);
                guard++;
            end
            if (guard >= 64) chk("drain_timeout", 32'd0, 32'd1);
        end
        @(negedge clk_i);
        chk("drain_exit_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
        chk("drain_exit_ready", {31'd0, req_ready_o}, 32'd1);
        chk("drain_exit_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        $display("kill during run drained");

        eng_lat = 4'd3;
        run_op(3'b000, 32'd3, 32'd3, 5'd9, 32'd9, 2'd0, 2'b00, 0);
        run_op(3'b000, 32'd5, 32'd5, 5'd25, 32'd25, 2'd0, 2'b00, 5);

        // Kill in RESP wins over wb_ready.
        issue(3'b000, 32'd2, 32'd2, 5'd4);
        wait_ready(2'd0);
        kill_i     = 1'b1;
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        kill_i     = 1'b0;
        wb_ready_i = 1'b0;
        chk("kill_resp_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("kill_resp_ready", {31'd0, req_ready_o}, 32'd1);
        $display("kill during resp dropped result");

        // Reset mid-divide.
        eng_lat = 4'd10;
        issue(3'b100, 32'd1000, 32'd3, 5'd8);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_mid_en", {30'd0, mult_en_o, div_en_o}, 32'd0);
        chk("rst_mid_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_mid_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_mid_op_a", op_a_o, 32'd0);
        $display("reset mid-divide returned to idle");

        eng_lat = 4'd6;
        run_op(3'b101, 32'd9, 32'd2, 5'd31, 32'd4, 2'd2, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
